// File: rtl/vic_ext_sync.sv
// vic_ext_sync: external interrupt input conditioning ahead of the vectored
// interrupt controller. Each raw line is synchronised into the clk domain.
// When VIC_EXT_FILTER_EN is defined, a per-line persistence filter also
// rejects glitches. The result is a registered, clean level vector.
//
// Build option:
//   VIC_EXT_FILTER_EN  - defined:   per-line counters and the persistence filter
//                                   are present.
//                        undefined: o_ext follows the synchroniser output, and
//                                   i_filt_len is ignored.
//
// Ports:
//   clk         - block clock
//   rst         - synchronous, active-high reset
//   i_irq_raw   - asynchronous external interrupt lines
//   i_filt_len  - extra consecutive cycles a new level must persist
//                 (quasi-static configuration)
//   o_ext       - conditioned interrupt levels (drives the controller's i_ext)
//   o_change    - one-cycle pulse per bit of o_ext that toggled on this edge
module vic_ext_sync #(
  parameter int unsigned N_IRQ       = 31,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IRQ-1:0]  i_irq_raw,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic [N_IRQ-1:0]  o_ext,
  output logic [N_IRQ-1:0]  o_change
);

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] ext_d;
  logic [N_IRQ-1:0] chg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= i_irq_raw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef VIC_EXT_FILTER_EN
  logic [FILT_W-1:0] cnt_q [N_IRQ];
  logic [FILT_W-1:0] cnt_d [N_IRQ];

  // A line's counter runs only while the synchronised level disagrees with
  // the accepted level. The comparison uses the live i_filt_len, so lowering
  // it below a running count accepts the new level on the next edge.
  always_comb begin
    ext_d = o_ext;
    chg_d = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      cnt_d[i] = '0;
      if (s[i] != o_ext[i]) begin
        if (cnt_q[i] >= i_filt_len) begin
          ext_d[i] = s[i];
          chg_d[i] = 1'b1;
        end else if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_IRQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_IRQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  logic unused_filt_len;
  assign unused_filt_len = ^i_filt_len;

  always_comb begin
    ext_d = s;
    chg_d = s ^ o_ext;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_ext    <= '0;
      o_change <= '0;
    end else begin
      o_ext    <= ext_d;
      o_change <= chg_d;
    end
  end

endmodule

// File: tb/tb_vic_ext_sync.sv
// Testbench for vic_ext_sync: a table of reset/latency vectors, hand-written
// multi-cycle sequences, and randomized traffic checked every cycle against
// a behavioural model.
module tb_vic_ext_sync;

  localparam int N  = 31;
  localparam int SS = 2;
  localparam int FW = 4;
`ifdef VIC_EXT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  raw;
  logic [FW-1:0] flen;
  logic [N-1:0]  o_ext;
  logic [N-1:0]  o_change;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state: history of sampled raw inputs, accepted levels,
  // and the length of the current disagreement run per line.
  logic [N-1:0] m_hist [SS];
  logic [N-1:0] m_out;
  logic [N-1:0] m_chg;
  int           m_run [N];

  typedef struct {
    logic         rst;
    logic [N-1:0] raw;
    logic [FW-1:0] flen;
    logic [N-1:0] ext;
    logic [N-1:0] chg;
  } vec_t;

  vec_t vt [17];

  vic_ext_sync #(.N_IRQ(N), .SYNC_STAGES(SS), .FILT_W(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_irq_raw (raw),
    .i_filt_len(flen),
    .o_ext     (o_ext),
    .o_change  (o_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Applies the block's rules for one clock edge using the current inputs.
  task automatic model_edge();
    logic [N-1:0] sv;
    if (rst) begin
      for (int k = 0; k < SS; k++) m_hist[k] = '0;
      m_out = '0;
      m_chg = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      sv    = m_hist[SS-1];
      m_chg = '0;
      for (int i = 0; i < N; i++) begin
        if (!FILT) begin
          m_chg[i] = sv[i] ^ m_out[i];
          m_out[i] = sv[i];
        end else if (sv[i] == m_out[i]) begin
          m_run[i] = 0;
        end else if (m_run[i] >= int'(flen)) begin
          m_out[i] = sv[i];
          m_chg[i] = 1'b1;
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
        end
      end
      for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick_chk(input string name);
    tick();
    chk({name, "_ext"}, o_ext, m_out);
    chk({name, "_chg"}, o_change, m_chg);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    raw = '0;
    tick_chk("rst");
    tick_chk("rst");
    rst = 1'b0;
  endtask

  // Drives line idx high for `hold` edges (counted from 1), and records the
  // first edge o_ext[idx] is high, how many edges it is high, and the number
  // of change pulses on that line.
  task automatic run_line(input int idx, input int hold, input int ticks,
                          output int rise, output int highs, output int pulses);
    rise = -1; highs = 0; pulses = 0;
    for (int t = 1; t <= ticks; t++) begin
      raw[idx] = (t <= hold);
      tick_chk("seq");
      if (o_ext[idx] === 1'b1 && rise < 0) rise = t;
      if (o_ext[idx] === 1'b1) highs++;
      if (o_change[idx] === 1'b1) pulses++;
    end
  endtask

  initial begin
    int rise, highs, pulses, lat;
    logic [N-1:0] ones;
    logic [N-1:0] simul;
    ones  = '1;
    simul = 31'h4000_8001;

    // Reset with all lines high, release, then drop all lines (i_filt_len=0).
    for (int i = 0; i < 3; i++) vt[i] = '{1'b1, ones, 4'd0, '0, '0};
    vt[3]  = '{1'b0, ones, 4'd0, '0,   '0};
    vt[4]  = '{1'b0, ones, 4'd0, '0,   '0};
    vt[5]  = '{1'b0, ones, 4'd0, ones, ones};
    vt[6]  = '{1'b0, ones, 4'd0, ones, '0};
    vt[7]  = '{1'b0, ones, 4'd0, ones, '0};
    vt[8]  = '{1'b0, '0,   4'd0, ones, '0};
    vt[9]  = '{1'b0, '0,   4'd0, ones, '0};
    vt[10] = '{1'b0, '0,   4'd0, '0,   ones};
    vt[11] = '{1'b0, '0,   4'd0, '0,   '0};
    vt[12] = '{1'b0, simul, 4'd0, '0,   '0};
    vt[13] = '{1'b0, simul, 4'd0, '0,   '0};
    vt[14] = '{1'b0, simul, 4'd0, simul, simul};
    vt[15] = '{1'b0, '0,   4'd0, simul, '0};
    vt[16] = '{1'b0, '0,   4'd0, simul, '0};

    rst = 1'b1; raw = '0; flen = '0;
    for (int i = 0; i < 17; i++) begin
      rst  = vt[i].rst;
      raw  = vt[i].raw;
      flen = vt[i].flen;
      tick();
      chk($sformatf("vec%0d_ext", i), o_ext, vt[i].ext);
      chk($sformatf("vec%0d_chg", i), o_change, vt[i].chg);
    end

    // Glitch reject then accept on line 5.
    do_reset();
    flen = 4'd3;
    run_line(5, 3, 12, rise, highs, pulses);
    chk_int("glitch_rise",   rise,   FILT ? -1 : 3);
    chk_int("glitch_pulses", pulses, FILT ? 0 : 2);
    run_line(5, 1000, 10, rise, highs, pulses);
    chk_int("hold_rise",   rise,   FILT ? 6 : 3);
    chk_int("hold_pulses", pulses, 1);

    // Lowering i_filt_len below a running count.
    do_reset();
    flen = 4'd10;
    raw[0] = 1'b1;
    for (int t = 0; t < 6; t++) tick_chk("fchg");
    chk("fchg_before", {30'd0, o_ext[0]}, FILT ? '0 : 31'd1);
    flen = 4'd2;
    tick_chk("fchg");
    chk("fchg_after",     {30'd0, o_ext[0]},    31'd1);
    chk("fchg_after_chg", {30'd0, o_change[0]}, FILT ? 31'd1 : '0);

    // Simultaneous lines with i_filt_len=1.
    do_reset();
    flen = 4'd1;
    raw  = simul;
    lat  = FILT ? 4 : 3;
    for (int t = 1; t <= lat + 1; t++) begin
      tick_chk("sim");
      if (t == lat - 1) chk("sim_pre_ext", o_ext, '0);
      if (t == lat) begin
        chk("sim_ext", o_ext, simul);
        chk("sim_chg", o_change, simul);
      end
      if (t == lat + 1) chk("sim_post_chg", o_change, '0);
    end

    // Reset mid-count restarts the full latency.
    do_reset();
    flen = 4'd7;
    raw[2] = 1'b1;
    for (int t = 0; t < 5; t++) tick_chk("rmid");
    rst = 1'b1;
    tick_chk("rmid");
    chk("rmid_in_rst", o_ext, '0);
    rst = 1'b0;
    run_line(2, 1000, 12, rise, highs, pulses);
    chk_int("rmid_rise", rise, FILT ? 10 : 3);

    // Single-cycle pulse with i_filt_len=15.
    do_reset();
    flen = 4'd15;
    run_line(9, 1, 8, rise, highs, pulses);
    chk_int("pulse_rise",   rise,   FILT ? -1 : 3);
    chk_int("pulse_highs",  highs,  FILT ? 0 : 1);
    chk_int("pulse_pulses", pulses, FILT ? 0 : 2);

    // Randomized traffic: sparse toggles (mix of glitches and persistent
    // levels), occasional filter-length changes and resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      raw = raw ^ N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) flen = FW'($urandom_range(0, 4));
      if ($urandom_range(0, 399) == 0) flen = FW'($urandom_range(0, 15));
      rst = ($urandom_range(0, 499) == 0);
      tick_chk("rnd");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
